// File: rtl/stats_record_pkg.sv
// Shared types and constants for the periodic statistics recorder.
`ifndef NOC_DATA_BYTES_W
`define NOC_DATA_BYTES_W 4
`endif

package stats_record_pkg;

  // Width of the dropped-snapshot counter presented with every snapshot.
  localparam int DROPS_W = 16;

  // IDLE: no snapshot held. PEND: snapshot held and offered to the log sink.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } rec_state_e;

  // Increment the drop count, sticking at all-ones instead of wrapping.
  function automatic logic [DROPS_W-1:0] drops_incr_sat(input logic [DROPS_W-1:0] drops);
    logic [DROPS_W-1:0] result;
    if (drops == {DROPS_W{1'b1}}) begin
      result = drops;
    end else begin
      result = drops + DROPS_W'(1'b1);
    end
    return result;
  endfunction

endpackage

// File: rtl/stats_cntr.sv
// One event counter channel: accumulates a per-cycle amount with wrap or
// saturate behaviour, and optionally restarts from the current amount on a
// record tick so interval deltas lose or double-count nothing.
module stats_cntr #(
  parameter int INCR_W          = 5,
  parameter int CNTR_W          = 64,
  parameter bit SATURATE        = 1'b0,
  parameter bit CLEAR_ON_RECORD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              incr_val,
  input  logic [INCR_W-1:0] incr_amt,
  input  logic              tick,
  output logic [CNTR_W-1:0] cnt
);

  logic [CNTR_W-1:0] cnt_r;
  logic [CNTR_W-1:0] cnt_s;
  logic [CNTR_W-1:0] amt_ext_s;
  logic [CNTR_W:0]   sum_s;

  assign amt_ext_s = CNTR_W'(incr_amt);
  assign sum_s     = {1'b0, cnt_r} + {1'b0, amt_ext_s};
  assign cnt       = cnt_r;

  // Next counter value: restart on tick in delta mode, else add with wrap/clamp.
  always_comb begin
    cnt_s = cnt_r;
    if (tick && CLEAR_ON_RECORD) begin
      // The tick-cycle increment belongs to the new interval.
      if (incr_val) begin
        cnt_s = amt_ext_s;
      end else begin
        cnt_s = {CNTR_W{1'b0}};
      end
    end else if (incr_val) begin
      if (SATURATE && sum_s[CNTR_W]) begin
        cnt_s = {CNTR_W{1'b1}};
      end else begin
        cnt_s = sum_s[CNTR_W-1:0];
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNTR_W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end

endmodule

// File: rtl/stats_record_multi.sv
// Periodic statistics recorder: a free-running timestamp and NUM_CNTRS event
// counters are snapshotted every RECORD_PERIOD cycles while record_en is high
// and offered to a log sink over a valid/ready handshake. Snapshots that
// arrive while the previous one is still waiting are dropped and counted.
// rst_n is expected to be released synchronously to clk by the reset
// controller, so the first timestamp increment lands on the first edge after
// release.
module stats_record_multi
  import stats_record_pkg::*;
#(
  parameter int NUM_CNTRS       = 2,
  parameter int INCR_W          = `NOC_DATA_BYTES_W + 1,
  parameter int CNTR_W          = 64,
  parameter int TIMESTAMP_W     = 64,
  parameter int RECORD_PERIOD   = 1024,
  parameter bit CLEAR_ON_RECORD = 1'b0,
  parameter bit SATURATE        = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        record_en,
  input  logic [NUM_CNTRS-1:0]        cntr_incr_val,
  input  logic [NUM_CNTRS*INCR_W-1:0] cntr_incr_amt,
  output logic                        log_wr_req_val,
  input  logic                        log_wr_req_rdy,
  output logic [TIMESTAMP_W-1:0]      log_wr_req_timestamp,
  output logic [NUM_CNTRS*CNTR_W-1:0] log_wr_req_cntrs,
  output logic [DROPS_W-1:0]          log_wr_req_drops
);

  localparam int                  PERIOD_W    = $clog2(RECORD_PERIOD);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(RECORD_PERIOD - 1);

  logic [TIMESTAMP_W-1:0]      timestamp_r;
  logic [PERIOD_W-1:0]         period_r;
  logic                        tick_s;
  logic [NUM_CNTRS*CNTR_W-1:0] cnt_s;

  rec_state_e                  state_r;
  rec_state_e                  state_s;
  logic                        capture_s;
  logic                        val_r;
  logic                        val_s;
  logic [DROPS_W-1:0]          drops_r;
  logic [DROPS_W-1:0]          drops_s;
  logic [TIMESTAMP_W-1:0]      snap_ts_r;
  logic [NUM_CNTRS*CNTR_W-1:0] snap_cntrs_r;

  // Tick on the last cycle of each period; never while recording is off.
  assign tick_s = record_en && (period_r == PERIOD_LAST);

  // Free-running timestamp, independent of record_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timestamp_r <= {TIMESTAMP_W{1'b0}};
    end else begin
      timestamp_r <= timestamp_r + TIMESTAMP_W'(1'b1);
    end
  end

  // Period counter: held at zero while disabled so a re-enable starts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_r <= {PERIOD_W{1'b0}};
    end else if (!record_en) begin
      period_r <= {PERIOD_W{1'b0}};
    end else if (period_r == PERIOD_LAST) begin
      period_r <= {PERIOD_W{1'b0}};
    end else begin
      period_r <= period_r + PERIOD_W'(1'b1);
    end
  end

  // Counter channels; delta-mode clearing follows every tick, dropped or not.
  for (genvar gi = 0; gi < NUM_CNTRS; gi++) begin : g_cntr
    stats_cntr #(
      .INCR_W          (INCR_W),
      .CNTR_W          (CNTR_W),
      .SATURATE        (SATURATE),
      .CLEAR_ON_RECORD (CLEAR_ON_RECORD)
    ) u_cntr (
      .clk      (clk),
      .rst_n    (rst_n),
      .incr_val (cntr_incr_val[gi]),
      .incr_amt (cntr_incr_amt[gi*INCR_W +: INCR_W]),
      .tick     (tick_s),
      .cnt      (cnt_s[gi*CNTR_W +: CNTR_W])
    );
  end

  // Handshake FSM: decides capture, drop accounting and the next valid state.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    val_s     = val_r;
    drops_s   = drops_r;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          // Drops are already zero here unless the sink never drained them.
          capture_s = 1'b1;
          drops_s   = drops_r;
          state_s   = PEND;
          val_s     = 1'b1;
        end else begin
          state_s = IDLE;
          val_s   = 1'b0;
        end
      end
      PEND: begin
        if (log_wr_req_rdy) begin
          drops_s = {DROPS_W{1'b0}};
          if (tick_s) begin
            // Old snapshot leaves this cycle, new one replaces it.
            capture_s = 1'b1;
            state_s   = PEND;
            val_s     = 1'b1;
          end else begin
            state_s = IDLE;
            val_s   = 1'b0;
          end
        end else begin
          state_s = PEND;
          val_s   = 1'b1;
          if (tick_s) begin
            drops_s = drops_incr_sat(drops_r);
          end else begin
            drops_s = drops_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        val_s   = 1'b0;
        drops_s = {DROPS_W{1'b0}};
      end
    endcase
  end

  // FSM state, valid and drop-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      val_r   <= 1'b0;
      drops_r <= {DROPS_W{1'b0}};
    end else begin
      state_r <= state_s;
      val_r   <= val_s;
      drops_r <= drops_s;
    end
  end

  // Snapshot registers: load pre-update timestamp and counters on capture only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_ts_r    <= {TIMESTAMP_W{1'b0}};
      snap_cntrs_r <= {(NUM_CNTRS*CNTR_W){1'b0}};
    end else if (capture_s) begin
      snap_ts_r    <= timestamp_r;
      snap_cntrs_r <= cnt_s;
    end else begin
      snap_ts_r    <= snap_ts_r;
      snap_cntrs_r <= snap_cntrs_r;
    end
  end

  assign log_wr_req_val       = val_r;
  assign log_wr_req_timestamp = snap_ts_r;
  assign log_wr_req_cntrs     = snap_cntrs_r;
  assign log_wr_req_drops     = drops_r;

endmodule

// File: tb/tb_stats_record_multi.sv
// Directed bench for stats_record_multi: four instances share clock, reset,
// record_en and ready; they differ in counter mode and width.
module tb_stats_record_multi;

  localparam int NC = 2;
  localparam int IW = 8;
  localparam int CW = 16;
  localparam int TW = 16;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic record_en;
  logic rdy;

  logic [NC-1:0]    main_val;
  logic [NC*IW-1:0] main_amt;
  logic             main_v;
  logic [TW-1:0]    main_ts;
  logic [NC*CW-1:0] main_cntrs;
  logic [15:0]      main_drops;

  logic [NC-1:0]    clr_val;
  logic [NC*IW-1:0] clr_amt;
  logic             clr_v;
  logic [TW-1:0]    clr_ts;
  logic [NC*CW-1:0] clr_cntrs;
  logic [15:0]      clr_drops;

  logic [0:0]       sat_val;
  logic [7:0]       sat_amt;
  logic             sat_v;
  logic [TW-1:0]    sat_ts;
  logic [7:0]       sat_cntrs;
  logic [15:0]      sat_drops;
  logic             wrp_v;
  logic [TW-1:0]    wrp_ts;
  logic [7:0]       wrp_cntrs;
  logic [15:0]      wrp_drops;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  logic exp_v;

  always #5 clk = ~clk;

  stats_record_multi #(.NUM_CNTRS(NC), .INCR_W(IW), .CNTR_W(CW), .TIMESTAMP_W(TW),
    .RECORD_PERIOD(RP), .CLEAR_ON_RECORD(1'b0), .SATURATE(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .record_en(record_en),
    .cntr_incr_val(main_val), .cntr_incr_amt(main_amt),
    .log_wr_req_val(main_v), .log_wr_req_rdy(rdy),
    .log_wr_req_timestamp(main_ts), .log_wr_req_cntrs(main_cntrs),
    .log_wr_req_drops(main_drops));

  stats_record_multi #(.NUM_CNTRS(NC), .INCR_W(IW), .CNTR_W(CW), .TIMESTAMP_W(TW),
    .RECORD_PERIOD(RP), .CLEAR_ON_RECORD(1'b1), .SATURATE(1'b0)) u_clr (
    .clk(clk), .rst_n(rst_n), .record_en(record_en),
    .cntr_incr_val(clr_val), .cntr_incr_amt(clr_amt),
    .log_wr_req_val(clr_v), .log_wr_req_rdy(rdy),
    .log_wr_req_timestamp(clr_ts), .log_wr_req_cntrs(clr_cntrs),
    .log_wr_req_drops(clr_drops));

  stats_record_multi #(.NUM_CNTRS(1), .INCR_W(8), .CNTR_W(8), .TIMESTAMP_W(TW),
    .RECORD_PERIOD(RP), .CLEAR_ON_RECORD(1'b0), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .record_en(record_en),
    .cntr_incr_val(sat_val), .cntr_incr_amt(sat_amt),
    .log_wr_req_val(sat_v), .log_wr_req_rdy(rdy),
    .log_wr_req_timestamp(sat_ts), .log_wr_req_cntrs(sat_cntrs),
    .log_wr_req_drops(sat_drops));

  stats_record_multi #(.NUM_CNTRS(1), .INCR_W(8), .CNTR_W(8), .TIMESTAMP_W(TW),
    .RECORD_PERIOD(RP), .CLEAR_ON_RECORD(1'b0), .SATURATE(1'b0)) u_wrp (
    .clk(clk), .rst_n(rst_n), .record_en(record_en),
    .cntr_incr_val(sat_val), .cntr_incr_amt(sat_amt),
    .log_wr_req_val(wrp_v), .log_wr_req_rdy(rdy),
    .log_wr_req_timestamp(wrp_ts), .log_wr_req_cntrs(wrp_cntrs),
    .log_wr_req_drops(wrp_drops));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: count the active edge, then return on the falling edge to sample.
  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic chk_main_zero(input string tag);
    chk({tag, "_val"}, main_v, 1'b0);
    chk({tag, "_ts"}, main_ts, 0);
    chk({tag, "_cntrs"}, main_cntrs, 0);
    chk({tag, "_drops"}, main_drops, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    record_en = 1'b1;
    rdy       = 1'b1;
    main_val  = 2'b01;
    main_amt  = {8'd0, 8'd3};
    clr_val   = 2'b01;
    clr_amt   = {8'd0, 8'd5};
    sat_val   = 1'b1;
    sat_amt   = 8'd100;
    repeat (2) @(negedge clk);
    chk_main_zero("reset");

    // Phase 1: rdy=1, one-cycle pulses at timestamps 7, 15, 23.
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 26; i++) begin
      step();
      if (k == 3) sat_val = 1'b0;
      exp_v = (k == 8 || k == 16 || k == 24);
      chk("p1_val", main_v, exp_v);
      if (exp_v) begin
        chk("p1_ts", main_ts, k - 1);
        chk("p1_ch0_cumulative", main_cntrs[15:0], 3 * (k - 1));
        chk("p1_ch1_idle", main_cntrs[31:16], 0);
        chk("p1_drops", main_drops, 0);
        // First interval holds 7 increments, later ones a full 8.
        chk("p1_clr_ch0", clr_cntrs[15:0], (k == 8) ? 35 : 40);
      end
      if (k == 8) begin
        chk("p1_sat_255", sat_cntrs, 8'd255);
        chk("p1_wrap_44", wrp_cntrs, 8'd44);
      end
    end

    // Phase 2: rdy low for three periods -> held snapshot, drops reach 2.
    rst_n = 1'b0;
    @(negedge clk);
    rdy   = 1'b0;
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 33; i++) begin
      step();
      if (k >= 8 && k <= 24) begin
        chk("p2_held_val", main_v, 1'b1);
        chk("p2_held_ts", main_ts, 7);
        chk("p2_held_ch0", main_cntrs[15:0], 21);
        chk("p2_drops", main_drops, (k < 16) ? 0 : ((k < 24) ? 1 : 2));
      end
      if (k == 24) rdy = 1'b1;
      if (k == 25) begin
        chk("p2_accept_val", main_v, 1'b0);
        chk("p2_accept_drops", main_drops, 0);
      end
      if (k == 32) begin
        chk("p2_next_val", main_v, 1'b1);
        chk("p2_next_ts", main_ts, 31);
        chk("p2_next_ch0", main_cntrs[15:0], 93);
        chk("p2_next_drops", main_drops, 0);
      end
      if (k == 33) chk("p2_next_done", main_v, 1'b0);
    end

    // Phase 3: hold a snapshot, drop record_en, then reset asynchronously.
    rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("p3_wait_val", main_v, (k == 40) ? 1'b1 : 1'b0);
    end
    record_en = 1'b0;
    step();
    chk("p3_keep_val", main_v, 1'b1);
    chk("p3_keep_ts", main_ts, 39);
    #2;
    rst_n = 1'b0;
    #1;
    chk_main_zero("async_rst");
    chk("async_rst_clr_val", clr_v, 1'b0);

    // Phase 4: enable toggle; next val exactly RECORD_PERIOD edges after re-enable.
    @(negedge clk);
    rdy       = 1'b1;
    record_en = 1'b1;
    rst_n     = 1'b1;
    k = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (k == 3) record_en = 1'b0;
      if (k == 10) record_en = 1'b1;
      chk("p4_val", main_v, (k == 18) ? 1'b1 : 1'b0);
      if (k == 18) chk("p4_ts", main_ts, 17);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
